avl_apb_completer: RTL and testbench



---
 rtl/avl_apb_pkg.sv | 21 ++
 rtl/avl_apb_addr_decode.sv | 34 +++
 rtl/avl_apb_completer.sv | 172 +++++++++++++++++
 tb/tb_avl_apb_completer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/avl_apb_pkg.sv
// rtl/avl_apb_pkg.sv - shared types and helpers for the APB completer
//
// Purpose : FSM state encoding, wait-counter width and lane-address helper
//           used by avl_apb_completer and avl_apb_addr_decode.
// Ports   : none (package)
package avl_apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Wait-state counter width; covers WAIT_STATES 0..15.
    localparam int CNT_W = 4;

    // Number of low address bits that select a byte lane within a data word.
    function automatic int lane_bits(input int data_width);
        return (data_width == 32) ? 2 : (data_width == 16) ? 1 : 0;
    endfunction

endpackage

// File: rtl/avl_apb_addr_decode.sv
// rtl/avl_apb_addr_decode.sv - byte address to register index and error flag
//
// Purpose : Combinational decode of paddr relative to BASE_ADDR.
// Ports   : paddr (in)  - byte address from the bus
//           idx   (out) - word index of the addressed register
//           err   (out) - misaligned or beyond the last register
module avl_apb_addr_decode
    import avl_apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    IDX_W      = 4
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    output logic [IDX_W-1:0]      idx,
    output logic                  err
);

    localparam int                    LB        = lane_bits(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << LB) - 1);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;

    // Subtraction wraps, so addresses below BASE_ADDR land far above the
    // register range and are flagged by the range test.
    assign offset = paddr - BASE_ADDR;
    assign word   = offset >> LB;
    assign idx    = word[IDX_W-1:0];
    assign err    = (|(offset & LANE_MASK)) || (word >= ADDR_WIDTH'(NUM_REGS));

endmodule

// File: rtl/avl_apb_completer.sv
// rtl/avl_apb_completer.sv - APB4 completer with a bank of R/W registers
//
// Purpose : Terminates APB transfers on a bank of NUM_REGS registers with
//           WAIT_STATES access-phase wait cycles and pslverr on bad addresses.
//           Define AVL_APB_COMPLETER_PSTRB_EN to honour pstrb byte lanes;
//           otherwise pstrb is ignored and every lane is written.
// Ports   : pclk, presetn          - clock, async active-low reset
//           psel, penable, pwrite  - APB control
//           paddr, pwdata, pstrb   - APB address, write data, byte strobes
//           pready, prdata, pslverr- APB response (completion cycle only)
//           reg_o                  - flat register contents
//           wr_o                   - per-register write pulse, aligned with reg_o
module avl_apb_completer
    import avl_apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           pclk,
    input  logic                           presetn,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            wr_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [NUM_REGS-1:0]   wr_q, wr_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err;
    logic                  complete;

`ifdef AVL_APB_COMPLETER_PSTRB_EN
    logic [NB-1:0]         strb_q, strb_d;
`else
    logic                  unused_pstrb;
    assign unused_pstrb = ^pstrb;
`endif

    avl_apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_decode (
        .paddr (paddr),
        .idx   (dec_idx),
        .err   (dec_err)
    );

    // Completion depends only on latched state and the bus control lines.
    assign complete = (state_q == ACCESS) && psel && penable && (cnt_q == '0);
    assign pready   = complete;
    assign pslverr  = complete && err_q;
    assign prdata   = (complete && !write_q && !err_q) ? regs_q[idx_q] : '0;
    assign wr_o     = wr_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_o
        assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        wr_d    = '0;
        regs_d  = regs_q;
`ifdef AVL_APB_COMPLETER_PSTRB_EN
        strb_d  = strb_q;
`endif

        case (state_q)
            IDLE: begin
                // penable without a preceding setup phase is ignored.
                if (psel && !penable) begin
                    write_d = pwrite;
                    idx_d   = dec_idx;
                    wdata_d = pwdata;
                    err_d   = dec_err;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ACCESS;
`ifdef AVL_APB_COMPLETER_PSTRB_EN
                    strb_d  = pstrb;
`endif
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete && write_q && !err_q) begin
`ifdef AVL_APB_COMPLETER_PSTRB_EN
            for (int b = 0; b < NB; b++) begin
                if (strb_q[b]) begin
                    regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
`else
            regs_d[idx_q] = wdata_q;
`endif
            // Pulses even for an all-zero strobe: the write still happened.
            wr_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
`ifdef AVL_APB_COMPLETER_PSTRB_EN
            strb_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            regs_q  <= regs_d;
`ifdef AVL_APB_COMPLETER_PSTRB_EN
            strb_q  <= strb_d;
`endif
        end
    end

endmodule

// File: tb/tb_avl_apb_completer.sv
// tb/tb_avl_apb_completer.sv - self-checking bench for avl_apb_completer
module tb_avl_apb_completer;

    localparam logic [31:0] RV3 = 32'h5A5A_0000;

    logic         pclk = 1'b0;
    logic         presetn;
    logic         psel0, psel3, penable, pwrite;
    logic [31:0]  paddr, pwdata;
    logic [3:0]   pstrb;

    logic         pready0, pslverr0, pready3, pslverr3;
    logic [31:0]  prdata0, prdata3;
    logic [511:0] reg0;
    logic [255:0] reg3;
    logic [15:0]  wr0;
    logic [7:0]   wr3;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    avl_apb_completer #(
        .NUM_REGS (16), .BASE_ADDR (32'h0), .WAIT_STATES (0), .RESET_VAL (32'h0)
    ) u_dut0 (
        .pclk (pclk), .presetn (presetn), .psel (psel0), .penable (penable),
        .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb),
        .pready (pready0), .prdata (prdata0), .pslverr (pslverr0),
        .reg_o (reg0), .wr_o (wr0)
    );

    avl_apb_completer #(
        .NUM_REGS (8), .BASE_ADDR (32'h1000), .WAIT_STATES (3), .RESET_VAL (RV3)
    ) u_dut3 (
        .pclk (pclk), .presetn (presetn), .psel (psel3), .penable (penable),
        .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb),
        .pready (pready3), .prdata (prdata3), .pslverr (pslverr3),
        .reg_o (reg3), .wr_o (wr3)
    );

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp;   // read data, or target register value after a write
        bit          err;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge
    // with the bus idle, so a following call forms a back-to-back transfer.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic err,
                        output int waits);
        bit done = 0;
        rd = '0; err = 1'b0; waits = 0;
        pwrite = w; paddr = a; pwdata = wd; pstrb = st; penable = 1'b0;
        if (d == 0) psel0 = 1'b1; else psel3 = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge pclk);
            if ((d == 0) ? pready0 : pready3) begin
                rd   = (d == 0) ? prdata0 : prdata3;
                err  = (d == 0) ? pslverr0 : pslverr3;
                done = 1;
            end else begin
                waits++;
            end
            @(posedge pclk); #1;
        end
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout: no pready at addr %h", a);
        end
    endtask

    logic [31:0]  rd;
    logic         er;
    int           ws;
    logic [511:0] snap;
    int           idx;

    initial begin
        presetn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;

        vt[0]  = '{1, 32'h08, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 0};
        vt[1]  = '{0, 32'h08, 32'h0,        4'hF, 32'hDEADBEEF, 0};
        vt[2]  = '{1, 32'h04, 32'h11223344, 4'hF, 32'h11223344, 0};
`ifdef AVL_APB_COMPLETER_PSTRB_EN
        vt[3]  = '{1, 32'h04, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, 0};
        vt[4]  = '{0, 32'h04, 32'h0,        4'hF, 32'h11BB33DD, 0};
`else
        vt[3]  = '{1, 32'h04, 32'hAABBCCDD, 4'b0101, 32'hAABBCCDD, 0};
        vt[4]  = '{0, 32'h04, 32'h0,        4'hF, 32'hAABBCCDD, 0};
`endif
        vt[5]  = '{1, 32'h40, 32'h12345678, 4'hF, 32'h0, 1};
        vt[6]  = '{1, 32'h02, 32'h12345678, 4'hF, 32'h0, 1};
        vt[7]  = '{0, 32'h40, 32'h0,        4'hF, 32'h0, 1};
        vt[8]  = '{0, 32'h3C, 32'h0,        4'hF, 32'h0, 0};
        vt[9]  = '{1, 32'h3C, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 0};
        vt[10] = '{0, 32'h3C, 32'h0,        4'hF, 32'hCAFEF00D, 0};
`ifdef AVL_APB_COMPLETER_PSTRB_EN
        vt[11] = '{1, 32'h3C, 32'h0,        4'h0, 32'hCAFEF00D, 0};
        vt[12] = '{0, 32'h3C, 32'h0,        4'hF, 32'hCAFEF00D, 0};
`else
        vt[11] = '{1, 32'h3C, 32'h0,        4'h0, 32'h0, 0};
        vt[12] = '{0, 32'h3C, 32'h0,        4'hF, 32'h0, 0};
`endif
        vt[13] = '{0, 32'h00, 32'h0,        4'hF, 32'h0, 0};
        vt[14] = '{0, 32'h43, 32'h0,        4'hF, 32'h0, 1};

        // Reset state
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_pready0", {31'b0, pready0}, 32'h0);
        chk("rst_prdata0", prdata0, 32'h0);
        chk("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
        chk("rst_wr0", {16'b0, wr0}, 32'h0);
        chk("rst_reg0", {31'b0, reg0 == '0}, 32'h1);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_reg3_%0d", i), reg3[i*32 +: 32], RV3);
        @(negedge pclk) presetn = 1'b1;
        @(posedge pclk); #1;

        // Table-driven transfers on the zero-wait completer
        for (int i = 0; i < 15; i++) begin
            snap = reg0;
            idx  = int'(vt[i].a[5:2]);
            xfer(0, vt[i].w, vt[i].a, vt[i].wd, vt[i].st, rd, er, ws);
            chk($sformatf("v%0d_waits", i), ws, 0);
            chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vt[i].err});
            chk($sformatf("v%0d_prdata", i), rd, vt[i].w ? 32'h0 : vt[i].exp);
            if (vt[i].w && !vt[i].err) begin
                chk($sformatf("v%0d_wr", i), {16'b0, wr0}, 32'(1) << idx);
                chk($sformatf("v%0d_reg", i), reg0[idx*32 +: 32], vt[i].exp);
            end else begin
                chk($sformatf("v%0d_nowr", i), {16'b0, wr0}, 32'h0);
                chk($sformatf("v%0d_unch", i), {31'b0, reg0 == snap}, 32'h1);
            end
            @(posedge pclk); #1;
            chk($sformatf("v%0d_wr_end", i), {16'b0, wr0}, 32'h0);
        end

        // Back-to-back write then read, no idle cycle between
        xfer(0, 1, 32'h10, 32'h0000A5A5, 4'hF, rd, er, ws);
        chk("b2b_wr_pulse", {16'b0, wr0}, 32'h0000_0010);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, rd, er, ws);
        chk("b2b_rd", rd, 32'h0000A5A5);
        chk("b2b_rd_waits", ws, 0);

        // Three wait states, non-zero base address
        xfer(3, 0, 32'h1000, 32'h0, 4'hF, rd, er, ws);
        chk("ws3_waits", ws, 3);
        chk("ws3_rd", rd, RV3);
        chk("ws3_err", {31'b0, er}, 32'h0);
        xfer(3, 0, 32'h101C, 32'h0, 4'hF, rd, er, ws);
        chk("ws3_last_rd", rd, RV3);
        xfer(3, 0, 32'h1020, 32'h0, 4'hF, rd, er, ws);
        chk("ws3_over_err", {31'b0, er}, 32'h1);
        chk("ws3_over_rd", rd, 32'h0);
        xfer(3, 0, 32'h0FFC, 32'h0, 4'hF, rd, er, ws);
        chk("ws3_below_err", {31'b0, er}, 32'h1);

        // Abort: psel drops after one access cycle
        pwrite = 1'b1; paddr = 32'h1004; pwdata = 32'h77; pstrb = 4'hF;
        penable = 1'b0; psel3 = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk($sformatf("abort_ready_%0d", i), {31'b0, pready3}, 32'h0);
            chk($sformatf("abort_wr_%0d", i), {24'b0, wr3}, 32'h0);
        end
        chk("abort_reg", reg3[32 +: 32], RV3);
        @(posedge pclk); #1;
        xfer(3, 1, 32'h1004, 32'h77, 4'hF, rd, er, ws);
        chk("post_abort_waits", ws, 3);
        chk("post_abort_wr", {24'b0, wr3}, 32'h2);
        chk("post_abort_reg", reg3[32 +: 32], 32'h77);

        // Reset during ACCESS of a write
        pwrite = 1'b1; paddr = 32'h1008; pwdata = 32'h99; pstrb = 4'hF;
        penable = 1'b0; psel3 = 1'b1;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk);
        chk("mid_ready", {31'b0, pready3}, 32'h0);
        #1 presetn = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, pready3}, 32'h0);
        chk("mid_rst_slverr", {31'b0, pslverr3}, 32'h0);
        chk("mid_rst_wr", {24'b0, wr3}, 32'h0);
        chk("mid_rst_reg1", reg3[32 +: 32], RV3);
        chk("mid_rst_reg2", reg3[64 +: 32], RV3);
        chk("mid_rst_reg0", {31'b0, reg0 == '0}, 32'h1);
        @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
        @(negedge pclk) presetn = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("post_rst_reg2", reg3[64 +: 32], RV3);
        chk("post_rst_wr", {24'b0, wr3}, 32'h0);
        xfer(3, 0, 32'h1008, 32'h0, 4'hF, rd, er, ws);
        chk("post_rst_rd", rd, RV3);
        chk("post_rst_waits", ws, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
